// File: rtl/fifo_rd_stream.sv
// Pop-side reader for a sync FIFO: turns pop/empty/data into a registered valid/ready
// stream through a 2-entry skid buffer, with frame marking. Optional stats: FIFO_RD_STATS_EN.
module fifo_rd_stream #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_pop_data_i,
    output logic              fifo_pop_o,
    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o,
    input  logic              m_ready_i,
    output logic [CNT_W-1:0]  stat_beats_o,
    output logic [CNT_W-1:0]  stat_stall_o
);
    localparam int BCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(FRAME_LEN - 1);

    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] slot0_q, slot0_d;
    logic [DATA_W-1:0] slot1_q, slot1_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              valid;
    logic              fire;
    logic              pop;

    assign valid = (cnt_q != 2'd0);
    assign fire  = valid & m_ready_i;
    // Pop depends only on occupancy and empty, so no path exists from m_ready_i to the FIFO.
    assign pop   = reset_n & ~fifo_empty_i & (cnt_q != 2'd2);

    always_comb begin
        cnt_d   = cnt_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case (cnt_q)
            2'd0: begin
                if (pop) begin
                    cnt_d   = 2'd1;
                    slot0_d = fifo_pop_data_i;
                end
            end
            2'd1: begin
                if (pop && fire) begin
                    slot0_d = fifo_pop_data_i;
                end else if (pop) begin
                    cnt_d   = 2'd2;
                    slot1_d = fifo_pop_data_i;
                end else if (fire) begin
                    cnt_d = 2'd0;
                end
            end
            2'd2: begin
                if (fire) begin
                    cnt_d   = 2'd1;
                    slot0_d = slot1_q;
                end
            end
            default: cnt_d = 2'd0;
        endcase

        bcnt_d = bcnt_q;
        if (fire) begin
            bcnt_d = (bcnt_q == LAST_BEAT) ? '0 : bcnt_q + BCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q   <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
            bcnt_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign fifo_pop_o = pop;
    assign m_valid_o  = valid;
    assign m_data_o   = slot0_q;
    assign m_last_o   = valid & (bcnt_q == LAST_BEAT);

`ifdef FIFO_RD_STATS_EN
    logic [CNT_W-1:0] beats_q;
    logic [CNT_W-1:0] stall_q;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            beats_q <= '0;
            stall_q <= '0;
        end else begin
            if (fire && (beats_q != '1)) begin
                beats_q <= beats_q + CNT_W'(1);
            end
            if (valid && !m_ready_i && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign stat_beats_o = beats_q;
    assign stat_stall_o = stall_q;
`else
    assign stat_beats_o = '0;
    assign stat_stall_o = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: array-backed FIFO model feeding the DUT, expected
// beats and frame positions computed here. Stats expectations follow FIFO_RD_STATS_EN.
module tb_fifo_rd_stream;
    localparam int DATA_W    = 8;
    localparam int FRAME_LEN = 4;
    localparam int CNT_W     = 16;
`ifdef FIFO_RD_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              m_ready_i = 1'b0;
    logic              fifo_empty_i;
    logic [DATA_W-1:0] fifo_pop_data_i;
    logic              fifo_pop_o;
    logic              m_valid_o;
    logic [DATA_W-1:0] m_data_o;
    logic              m_last_o;
    logic [CNT_W-1:0]  stat_beats_o;
    logic [CNT_W-1:0]  stat_stall_o;

    logic [7:0] mem [0:255];
    int rd_cnt = 0;
    int wr_cnt = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign fifo_empty_i    = (rd_cnt == wr_cnt);
    assign fifo_pop_data_i = mem[rd_cnt[7:0]];

    always @(posedge clk) begin
        if (fifo_pop_o) rd_cnt <= rd_cnt + 1;
    end

    fifo_rd_stream #(
        .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .fifo_empty_i(fifo_empty_i), .fifo_pop_data_i(fifo_pop_data_i),
        .fifo_pop_o(fifo_pop_o),
        .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o),
        .m_ready_i(m_ready_i),
        .stat_beats_o(stat_beats_o), .stat_stall_o(stat_stall_o)
    );

    task automatic push(input logic [7:0] v);
        mem[wr_cnt[7:0]] = v;
        wr_cnt++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        m_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", m_valid_o); end
        checks++; if (m_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", m_data_o); end
        checks++; if (m_last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", m_last_o); end
        checks++; if (fifo_pop_o !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b expected 0", fifo_pop_o); end
        checks++; if (stat_beats_o !== '0 || stat_stall_o !== '0) begin
            errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_beats_o, stat_stall_o);
        end
    endtask

    task automatic test_basic();
        logic [7:0] ev;
        do_reset();
        @(negedge clk);
        m_ready_i = 1'b1;
        push(8'h11); push(8'h22); push(8'h33);
        #1;
        checks++; if (fifo_pop_o !== 1'b1 || m_valid_o !== 1'b0) begin
            errors++; $display("FAIL basic_first_pop: got pop=%b valid=%b expected pop=1 valid=0", fifo_pop_o, m_valid_o);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            ev = 8'(8'h11 * (k + 1));
            $display("basic beat %0d data=%h last=%b", k, m_data_o, m_last_o);
            checks++; if (m_valid_o !== 1'b1 || m_data_o !== ev || m_last_o !== 1'b0) begin
                errors++; $display("FAIL basic_beat%0d: got v=%b d=%h l=%b expected v=1 d=%h l=0", k, m_valid_o, m_data_o, m_last_o, ev);
            end
            checks++; if (fifo_pop_o === 1'b1 && fifo_empty_i) begin
                errors++; $display("FAIL basic_pop_empty: got pop=1 expected 0 while empty");
            end
        end
        @(negedge clk); #1;
        checks++; if (m_valid_o !== 1'b0 || fifo_pop_o !== 1'b0) begin
            errors++; $display("FAIL basic_drained: got v=%b pop=%b expected 0/0", m_valid_o, fifo_pop_o);
        end
        checks++; if (stat_beats_o !== (STATS_ON ? CNT_W'(3) : '0)) begin
            errors++; $display("FAIL basic_stat_beats: got %0d expected %0d", stat_beats_o, STATS_ON ? 3 : 0);
        end
    endtask

    task automatic test_frame();
        logic [7:0] ev;
        logic       el;
        do_reset();
        @(negedge clk);
        m_ready_i = 1'b1;
        for (int k = 0; k < 12; k++) push(8'(8'h40 + k));
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); #1;
            ev = 8'(8'h40 + k);
            el = ((k % FRAME_LEN) == FRAME_LEN - 1);
            $display("frame beat %0d data=%h last=%b", k, m_data_o, m_last_o);
            checks++; if (m_valid_o !== 1'b1 || m_data_o !== ev || m_last_o !== el) begin
                errors++; $display("FAIL frame_beat%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", k, m_valid_o, m_data_o, m_last_o, ev, el);
            end
        end
        @(negedge clk); #1;
        checks++; if (m_valid_o !== 1'b0 || m_last_o !== 1'b0) begin
            errors++; $display("FAIL frame_idle: got v=%b l=%b expected 0/0", m_valid_o, m_last_o);
        end
        checks++; if (stat_beats_o !== (STATS_ON ? CNT_W'(12) : '0)) begin
            errors++; $display("FAIL frame_stat_beats: got %0d expected %0d", stat_beats_o, STATS_ON ? 12 : 0);
        end
    endtask

    task automatic test_stall();
        int rd0;
        logic [7:0] ev;
        do_reset();
        rd0 = rd_cnt;
        @(negedge clk);
        m_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) push(8'(8'h51 + k));
        #1;
        checks++; if (fifo_pop_o !== 1'b1 || m_valid_o !== 1'b0) begin
            errors++; $display("FAIL stall_fill: got pop=%b valid=%b expected 1/0", fifo_pop_o, m_valid_o);
        end
        for (int i = 1; i < 6; i++) begin
            @(negedge clk); #1;
            checks++; if (m_valid_o !== 1'b1 || m_data_o !== 8'h51 || m_last_o !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d: got v=%b d=%h l=%b expected v=1 d=51 l=0", i, m_valid_o, m_data_o, m_last_o);
            end
        end
        checks++; if (fifo_pop_o !== 1'b0 || (rd_cnt - rd0) != 2) begin
            errors++; $display("FAIL stall_pops: got pop=%b pops=%0d expected pop=0 pops=2", fifo_pop_o, rd_cnt - rd0);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            m_ready_i = 1'b1;
            #1;
            if (k == 0) begin
                checks++; if (stat_stall_o !== (STATS_ON ? CNT_W'(5) : '0)) begin
                    errors++; $display("FAIL stall_stat: got %0d expected %0d", stat_stall_o, STATS_ON ? 5 : 0);
                end
            end
            ev = 8'(8'h51 + k);
            $display("stall drain beat %0d data=%h last=%b", k, m_data_o, m_last_o);
            checks++; if (m_valid_o !== 1'b1 || m_data_o !== ev || m_last_o !== (k == 3)) begin
                errors++; $display("FAIL stall_drain%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", k, m_valid_o, m_data_o, m_last_o, ev, k == 3);
            end
        end
        @(negedge clk); #1;
        checks++; if (m_valid_o !== 1'b0 || stat_beats_o !== (STATS_ON ? CNT_W'(5) : '0)) begin
            errors++; $display("FAIL stall_end: got v=%b beats=%0d expected v=0 beats=%0d", m_valid_o, stat_beats_o, STATS_ON ? 5 : 0);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] e;
        logic [7:0] prev_data;
        logic       prev_last;
        logic       prev_hold;
        logic       rdy;
        int pushed, delivered, beat, stalls, cyc;
        pushed = 0; delivered = 0; beat = 0; stalls = 0; cyc = 0;
        prev_hold = 1'b0; prev_data = '0; prev_last = 1'b0;
        do_reset();
        while (delivered < 200 && cyc < 3000) begin
            @(negedge clk);
            if (pushed < 200 && $urandom_range(0, 1) == 1) begin
                e = 8'($urandom);
                push(e);
                exp_q.push_back(e);
                pushed++;
            end
            rdy = 1'($urandom_range(0, 1));
            m_ready_i = rdy;
            #1;
            cyc++;
            checks++; if (fifo_pop_o === 1'b1 && fifo_empty_i) begin
                errors++; $display("FAIL rand_pop_empty: got pop=1 expected 0 at cycle %0d", cyc);
            end
            if (prev_hold) begin
                checks++; if (m_valid_o !== 1'b1 || m_data_o !== prev_data || m_last_o !== prev_last) begin
                    errors++; $display("FAIL rand_stable: got v=%b d=%h l=%b expected v=1 d=%h l=%b", m_valid_o, m_data_o, m_last_o, prev_data, prev_last);
                end
            end
            if (m_valid_o === 1'b1 && rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious: got beat d=%h expected none", m_data_o);
                end else begin
                    e = exp_q.pop_front();
                    $display("rand beat %0d data=%h last=%b", delivered, m_data_o, m_last_o);
                    if (m_data_o !== e || m_last_o !== (beat == FRAME_LEN - 1)) begin
                        errors++; $display("FAIL rand_beat%0d: got d=%h l=%b expected d=%h l=%b", delivered, m_data_o, m_last_o, e, beat == FRAME_LEN - 1);
                    end
                end
                beat = (beat + 1) % FRAME_LEN;
                delivered++;
            end
            prev_hold = (m_valid_o === 1'b1) && !rdy;
            prev_data = m_data_o;
            prev_last = m_last_o;
            if (prev_hold) stalls++;
        end
        checks++; if (delivered != 200) begin
            errors++; $display("FAIL rand_timeout: got %0d beats expected 200", delivered);
        end
        @(negedge clk);
        m_ready_i = 1'b0;
        #1;
        checks++; if (m_valid_o !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL rand_drained: got v=%b left=%0d expected v=0 left=0", m_valid_o, exp_q.size());
        end
        checks++; if (stat_beats_o !== (STATS_ON ? CNT_W'(200) : '0)) begin
            errors++; $display("FAIL rand_stat_beats: got %0d expected %0d", stat_beats_o, STATS_ON ? 200 : 0);
        end
        checks++; if (stat_stall_o !== (STATS_ON ? CNT_W'(stalls) : '0)) begin
            errors++; $display("FAIL rand_stat_stall: got %0d expected %0d", stat_stall_o, STATS_ON ? stalls : 0);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] ev;
        logic [7:0] pre_d [0:3];
        logic       pre_r [0:3];
        pre_d[0] = 8'h61; pre_d[1] = 8'h62; pre_d[2] = 8'h63; pre_d[3] = 8'h63;
        pre_r[0] = 1'b1;  pre_r[1] = 1'b1;  pre_r[2] = 1'b0;  pre_r[3] = 1'b0;
        do_reset();
        @(negedge clk);
        m_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) push(8'(8'h61 + k));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m_ready_i = pre_r[i];
            #1;
            checks++; if (m_valid_o !== 1'b1 || m_data_o !== pre_d[i]) begin
                errors++; $display("FAIL rmid_pre%0d: got v=%b d=%h expected v=1 d=%h", i, m_valid_o, m_data_o, pre_d[i]);
            end
        end
        checks++; if (fifo_pop_o !== 1'b0) begin
            errors++; $display("FAIL rmid_full_pop: got %b expected 0", fifo_pop_o);
        end
        @(negedge clk);
        reset_n   = 1'b0;
        m_ready_i = 1'b0;
        #1;
        checks++; if (fifo_pop_o !== 1'b0) begin
            errors++; $display("FAIL rmid_pop_in_reset: got %b expected 0", fifo_pop_o);
        end
        @(posedge clk); #1;
        checks++; if (m_valid_o !== 1'b0 || m_data_o !== 8'h00 || m_last_o !== 1'b0 || fifo_pop_o !== 1'b0) begin
            errors++; $display("FAIL rmid_after_edge: got v=%b d=%h l=%b pop=%b expected 0/00/0/0", m_valid_o, m_data_o, m_last_o, fifo_pop_o);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        m_ready_i = 1'b1;
        #1;
        checks++; if (m_valid_o !== 1'b0 || fifo_pop_o !== 1'b1) begin
            errors++; $display("FAIL rmid_release: got v=%b pop=%b expected 0/1", m_valid_o, fifo_pop_o);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            ev = 8'(8'h65 + k);
            $display("rmid beat %0d data=%h last=%b", k, m_data_o, m_last_o);
            checks++; if (m_valid_o !== 1'b1 || m_data_o !== ev || m_last_o !== (k == 3)) begin
                errors++; $display("FAIL rmid_beat%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", k, m_valid_o, m_data_o, m_last_o, ev, k == 3);
            end
        end
        @(negedge clk); #1;
        checks++; if (m_valid_o !== 1'b0 || rd_cnt != wr_cnt) begin
            errors++; $display("FAIL rmid_end: got v=%b fifo_left=%0d expected 0/0", m_valid_o, wr_cnt - rd_cnt);
        end
        checks++; if (stat_beats_o !== (STATS_ON ? CNT_W'(4) : '0) || stat_stall_o !== '0) begin
            errors++; $display("FAIL rmid_stats: got %0d/%0d expected %0d/0", stat_beats_o, stat_stall_o, STATS_ON ? 4 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame();
        test_stall();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
